vector_load_unit: RTL and testbench
===================================

VECTOR_LOAD_UNIT -- requirements
Module: vector_load_unit

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, meaning element width in bits.
REQ-002 SHALL have parameter LANES, default 8, meaning elements per vector (LANES >= 2).
REQ-003 SHALL have parameter ADDR_SIZE, default 32, meaning memory word-address width.
REQ-004 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port START  input  1  request a vector load; sampled only in IDLE.
REQ-007 SHALL have port BASE_ADDR  input  ADDR_SIZE  word address of lane 0.
REQ-008 SHALL have port STRIDE  input  ADDR_SIZE  word-address increment between lanes.
REQ-009 SHALL have port MEM_RD  output  1  memory read strobe.
REQ-010 SHALL have port MEM_ADDR  output  ADDR_SIZE  memory read address.
REQ-011 SHALL have port MEM_DATA  input  DATA_SIZE  read data, valid the cycle after MEM_RD.
REQ-012 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-013 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-014 SHALL have port VEC_WRITE  output  1  vector-register write enable, identical to DONE.
REQ-015 SHALL have port VEC_OUT  output  LANES*DATA_SIZE  assembled vector; lane i at bits [i*DATA_SIZE +: DATA_SIZE].

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, DRAIN, FINISH.
REQ-017 IDLE: START=1 at an edge SHALL latch BASE_ADDR and STRIDE, clear the issue and capture counters, and move to ISSUE.
REQ-018 ISSUE SHALL last exactly LANES cycles; in issue cycle i (0..LANES-1), MEM_RD=1 and MEM_ADDR=BASE+i*STRIDE.
REQ-019 Address arithmetic SHALL be modulo 2^ADDR_SIZE; wrap-around SHALL NOT be flagged; STRIDE=0 SHALL be legal and read the same word LANES times.
REQ-020 MEM_DATA present in the cycle after issue i SHALL be captured into lane i at the end of that cycle.
REQ-021 After the last issue, the FSM SHALL enter DRAIN for one cycle with MEM_RD=0 and capture lane LANES-1.
REQ-022 FINISH SHALL last one cycle with DONE=VEC_WRITE=1 and VEC_OUT holding all LANES captured elements; the FSM SHALL then return to IDLE.
REQ-023 Latency: START sampled at the end of cycle 0 SHALL produce DONE in cycle LANES+2; BUSY SHALL be high in cycles 1..LANES+2.
REQ-024 START while BUSY=1, including during FINISH, SHALL be ignored; a new request SHALL be accepted at the earliest in the cycle after FINISH.
REQ-025 Changes on BASE_ADDR or STRIDE after acceptance SHALL NOT affect the load in progress.
REQ-026 VEC_OUT SHALL hold its value between loads; lanes not yet captured in a load SHALL keep their previous values until overwritten.
REQ-027 MEM_ADDR SHALL be 0 whenever MEM_RD=0.

Reset
REQ-028 RST=0 SHALL immediately force state IDLE, clear both counters, and drive MEM_RD=0, MEM_ADDR=0, BUSY=0, DONE=0, VEC_WRITE=0, VEC_OUT=0.
REQ-029 Reset during any state SHALL abandon the load with no DONE pulse; the first START after release SHALL start a complete new load.

Structure
REQ-030 A shared package vec_pkg SHALL hold the FSM state enum and the DATA_SIZE, LANES, and ADDR_SIZE default constants.
REQ-031 Address generation (latched base, running sum, stride add) SHALL be one sub-module, vlu_addr_gen; the FSM and lane capture SHALL remain in the top module.

Verification
REQ-032 Basic load: BASE=0x10, STRIDE=1, memory[a]=a*3 -> MEM_ADDR 0x10..0x17 on consecutive cycles, DONE in cycle 10, and lane i = (0x10+i)*3.
REQ-033 Strided wrap: ADDR_SIZE=8, BASE=0xFC, STRIDE=2 -> addresses FC,FE,00,02,04,06,08,0A with no stall.
REQ-034 Busy START: START held high for 20 cycles -> exactly two loads, the second starting in the cycle after the first DONE, with one DONE pulse per load.
REQ-035 Mid-load reset: RST=0 in issue cycle 4 -> all outputs 0 immediately and no DONE; a following START produces a full correct load.
REQ-036 STRIDE=0 with BASE=0x20 and memory[0x20]=0xDEADBEEF -> all 8 lanes equal 0xDEADBEEF; BASE_ADDR changed mid-load -> no effect on the result.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the vector load unit.
//   - Default element width, lane count and address width.
//   - FSM state encoding, also exported on the top's state_dbg output.
package vec_pkg;

  localparam int DEF_DATA_SIZE = 32;
  localparam int DEF_LANES     = 8;
  localparam int DEF_ADDR_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } vlu_state_e;

endpackage

// File: rtl/vector_load_unit_if.sv
// Memory read bus between the vector load unit and its memory.
//   MEM_RD   : read strobe (master -> slave)
//   MEM_ADDR : word address, 0 whenever MEM_RD is low (master -> slave)
//   MEM_DATA : read data, valid the cycle after MEM_RD (slave -> master)
// There is no backpressure: the memory has a fixed one-cycle read latency,
// so every strobe is answered exactly one cycle later.
interface vector_load_unit_if
  import vec_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
);

  logic                 MEM_RD;
  logic [ADDR_SIZE-1:0] MEM_ADDR;
  logic [DATA_SIZE-1:0] MEM_DATA;

  modport master (
    output MEM_RD,
    output MEM_ADDR,
    input  MEM_DATA
  );

  modport slave (
    input  MEM_RD,
    input  MEM_ADDR,
    output MEM_DATA
  );

endinterface

// File: rtl/vlu_addr_gen.sv
// Strided address generator for the vector load unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture base_in/stride_in (running address := base)
//   advance    : step the running address by the latched stride
//   base_in    : word address of lane 0
//   stride_in  : increment between lanes
//   addr_out   : current running address
// Arithmetic wraps modulo 2^ADDR_SIZE with no indication.
module vlu_addr_gen
  import vec_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 advance,
  input  logic [ADDR_SIZE-1:0] base_in,
  input  logic [ADDR_SIZE-1:0] stride_in,
  output logic [ADDR_SIZE-1:0] addr_out
);

  // addr_q holds the latched base at load time and then the running sum.
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE-1:0] stride_q, stride_d;

  always_comb begin
    addr_d   = addr_q;
    stride_d = stride_q;
    if (load) begin
      addr_d   = base_in;
      stride_d = stride_in;
    end else if (advance) begin
      addr_d = addr_q + stride_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      stride_q <= '0;
    end else begin
      addr_q   <= addr_d;
      stride_q <= stride_d;
    end
  end

  assign addr_out = addr_q;

endmodule

// File: rtl/vector_load_unit.sv
// Vector load unit: gathers LANES elements from memory at BASE + i*STRIDE
// and presents them as one vector with a single-cycle write pulse.
//   CLK, RST   : clock, asynchronous active-low reset
//   START      : load request, sampled only in IDLE
//   BASE_ADDR  : word address of lane 0
//   STRIDE     : word-address increment between lanes
//   mem        : memory read bus (master side)
//   BUSY       : high in every state except IDLE
//   DONE       : one-cycle completion pulse (FINISH state)
//   VEC_WRITE  : vector-register write enable, same as DONE
//   VEC_OUT    : assembled vector, lane i at [i*DATA_SIZE +: DATA_SIZE]
//   state_dbg  : current FSM state
//
// Request protocol: START acts as a valid with an implicit ready of !BUSY.
// A request is accepted at a rising edge where START=1 and the FSM is in
// IDLE; START while BUSY (including FINISH) is dropped, not queued.
// BASE_ADDR/STRIDE are only sampled at acceptance.
module vector_load_unit
  import vec_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int LANES     = DEF_LANES,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic [ADDR_SIZE-1:0]       BASE_ADDR,
  input  logic [ADDR_SIZE-1:0]       STRIDE,
  vector_load_unit_if.master         mem,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       VEC_WRITE,
  output logic [LANES*DATA_SIZE-1:0] VEC_OUT,
  output vlu_state_e                 state_dbg
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  vlu_state_e state_q, state_d;
  logic [CW-1:0] issue_q, issue_d;
  logic [CW-1:0] cap_q, cap_d;
  // A read issued last cycle: its data is on MEM_DATA now.
  logic rd_dly_q, rd_dly_d;
  logic [LANES*DATA_SIZE-1:0] vec_q, vec_d;

  logic                 ag_load;
  logic                 ag_advance;
  logic [ADDR_SIZE-1:0] ag_addr;
  logic                 mem_rd;
  logic                 busy;
  logic                 done;

  vlu_addr_gen #(
    .ADDR_SIZE (ADDR_SIZE)
  ) u_addr_gen (
    .clk       (CLK),
    .rst_n     (RST),
    .load      (ag_load),
    .advance   (ag_advance),
    .base_in   (BASE_ADDR),
    .stride_in (STRIDE),
    .addr_out  (ag_addr)
  );

  always_comb begin
    state_d    = state_q;
    issue_d    = issue_q;
    cap_d      = cap_q;
    vec_d      = vec_q;
    ag_load    = 1'b0;
    ag_advance = 1'b0;
    mem_rd     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (START) begin
          ag_load = 1'b1;
          issue_d = '0;
          cap_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_rd     = 1'b1;
        ag_advance = 1'b1;
        issue_d    = issue_q + CW'(1);
        if (issue_q == LAST_LANE) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Capture trails issue by one cycle; DRAIN exists only to take the
    // last lane. Only the addressed lane changes, others keep old data.
    if (rd_dly_q) begin
      vec_d[int'(cap_q)*DATA_SIZE +: DATA_SIZE] = mem.MEM_DATA;
      cap_d = cap_q + CW'(1);
    end
  end

  assign rd_dly_d = mem_rd;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      issue_q  <= '0;
      cap_q    <= '0;
      rd_dly_q <= 1'b0;
      vec_q    <= '0;
    end else begin
      state_q  <= state_d;
      issue_q  <= issue_d;
      cap_q    <= cap_d;
      rd_dly_q <= rd_dly_d;
      vec_q    <= vec_d;
    end
  end

  // All outputs below decode from reset-cleared flops, so they drop to 0
  // as soon as RST asserts.
  assign mem.MEM_RD   = mem_rd;
  assign mem.MEM_ADDR = mem_rd ? ag_addr : '0;
  assign BUSY         = busy;
  assign DONE         = done;
  assign VEC_WRITE    = done;
  assign VEC_OUT      = vec_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_vector_load_unit.sv
// Directed bench for vector_load_unit (DATA_SIZE=32, LANES=8, ADDR_SIZE=8).
// A one-cycle-latency memory model answers reads; expected addresses and
// vectors are queued when a load is driven and popped by a monitor.
module tb_vector_load_unit;
  import vec_pkg::*;

  localparam int DW = 32;
  localparam int NL = 8;
  localparam int AW = 8;
  localparam int VW = DW * NL;

  logic          CLK;
  logic          RST;
  logic          START;
  logic [AW-1:0] BASE_ADDR;
  logic [AW-1:0] STRIDE;
  logic          BUSY;
  logic          DONE;
  logic          VEC_WRITE;
  logic [VW-1:0] VEC_OUT;
  vlu_state_e    state_dbg;

  vector_load_unit_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) mem_if ();

  vector_load_unit #(
    .DATA_SIZE (DW),
    .LANES     (NL),
    .ADDR_SIZE (AW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .BASE_ADDR (BASE_ADDR),
    .STRIDE    (STRIDE),
    .mem       (mem_if.master),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .VEC_WRITE (VEC_WRITE),
    .VEC_OUT   (VEC_OUT),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [256];

  always @(posedge CLK) begin
    if (mem_if.MEM_RD) mem_if.MEM_DATA <= mem[mem_if.MEM_ADDR];
    else               mem_if.MEM_DATA <= '0;
  end

  // ---------------- scoreboard ----------------
  logic [AW-1:0] addr_exp_q[$];
  logic [VW-1:0] vec_exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (mem_if.MEM_RD) begin
        if (addr_exp_q.size() > 0) check("mem_addr", mem_if.MEM_ADDR, addr_exp_q.pop_front());
        else                       check("spurious_rd", mem_if.MEM_RD, 0);
      end else begin
        check("addr_zero_idle", mem_if.MEM_ADDR, 0);
      end
      if (DONE) begin
        done_cnt++;
        check("vec_write_eq_done", VEC_WRITE, 1);
        if (vec_exp_q.size() > 0) check("vec_out", VEC_OUT, vec_exp_q.pop_front());
        else                      check("spurious_done", DONE, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [VW-1:0] push_load(input logic [AW-1:0] base, input logic [AW-1:0] stride);
    logic [VW-1:0] v;
    logic [AW-1:0] a;
    v = '0;
    for (int i = 0; i < NL; i++) begin
      a = base + AW'(i) * stride;
      addr_exp_q.push_back(a);
      v[i*DW +: DW] = mem[a];
    end
    vec_exp_q.push_back(v);
    return v;
  endfunction

  // One request, then track BUSY/DONE timing relative to the accepting edge.
  task automatic do_load(input logic [AW-1:0] base, input logic [AW-1:0] stride);
    logic [VW-1:0] v;
    int            k_done;
    v = push_load(base, stride);
    @(negedge CLK);
    START = 1'b1; BASE_ADDR = base; STRIDE = stride;
    @(posedge CLK);
    #1;
    START = 1'b0;
    // Inputs move right after acceptance; the load must not notice.
    BASE_ADDR = AW'($urandom);
    STRIDE    = AW'($urandom_range(1, 255));
    k_done = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLK);
      if (k == 1) check("busy_cycle1", BUSY, 1);
      if (DONE) begin
        k_done = k;
        break;
      end
    end
    if (k_done == 0) check("done_timeout", DONE, 1);
    else             check("done_latency", k_done, NL + 2);
    @(negedge CLK);
    check("busy_after_finish", BUSY, 0);
    repeat (3) @(negedge CLK);
    check("vec_hold", VEC_OUT, v);
  endtask

  // ---------------- test sequence ----------------
  int first_done;
  int second_done;
  int done_before;

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = DW'(a * 3);
    RST = 1'b0; START = 1'b0; BASE_ADDR = '0; STRIDE = '0;
    mem_if.MEM_DATA = '0;
    #12;
    check("rst_mem_rd", mem_if.MEM_RD, 0);
    check("rst_mem_addr", mem_if.MEM_ADDR, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_vec_write", VEC_WRITE, 0);
    check("rst_vec_out", VEC_OUT, 0);
    check("rst_state", state_dbg, IDLE);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Basic unit-stride load; lane i = (0x10+i)*3.
    do_load(8'h10, 8'h01);

    // Strided wrap-around: FC,FE,00,02,...,0A.
    do_load(8'hFC, 8'h02);

    // START held high for 20 edges: exactly two loads, back to back.
    void'(push_load(8'h40, 8'h03));
    void'(push_load(8'h40, 8'h03));
    first_done = 0; second_done = 0;
    @(negedge CLK);
    START = 1'b1; BASE_ADDR = 8'h40; STRIDE = 8'h03;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (k == 20) START = 1'b0;
      if (DONE) begin
        if (first_done == 0) first_done = k;
        else if (second_done == 0) second_done = k;
      end
    end
    check("busy_start_first_done", first_done, NL + 2);
    check("busy_start_second_done", second_done, 2 * NL + 5);

    // Mid-load reset in issue cycle 4: five reads then abandon.
    for (int i = 0; i < 5; i++) addr_exp_q.push_back(8'h80 + AW'(i));
    done_before = done_cnt;
    @(negedge CLK);
    START = 1'b1; BASE_ADDR = 8'h80; STRIDE = 8'h01;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (5) @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("mrst_mem_rd", mem_if.MEM_RD, 0);
    check("mrst_mem_addr", mem_if.MEM_ADDR, 0);
    check("mrst_busy", BUSY, 0);
    check("mrst_done", DONE, 0);
    check("mrst_vec_write", VEC_WRITE, 0);
    check("mrst_vec_out", VEC_OUT, 0);
    check("mrst_state", state_dbg, IDLE);
    check("mrst_reads_issued", addr_exp_q.size(), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (15) @(negedge CLK);
    check("mrst_no_done", done_cnt, done_before);
    do_load(8'h80, 8'h01);

    // Stride 0 on a single word, base moved mid-load.
    mem[8'h20] = 32'hDEADBEEF;
    do_load(8'h20, 8'h00);

    // A couple of random loads.
    for (int r = 0; r < 2; r++) begin
      do_load(AW'($urandom_range(0, 255)), AW'($urandom_range(0, 255)));
    end

    check("addr_queue_empty", addr_exp_q.size(), 0);
    check("vec_queue_empty", vec_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
